mul_issue_collect: RTL and testbench
====================================

Name: mul_issue_collect

Overview:
- Wrapper-side control stage around the fixed-latency pipelined shift-add multiplier (16×16, one SUBMODULE stage per multiplier bit, no stall or valid).
- Upstream side: accepts operand pairs over a valid/ready handshake and drives the multiplier's multiplicand/multiplier inputs.
- Tracks each issued operation through the pipeline with a valid/tag shift register, then captures the matching Product into a result FIFO.
- Downstream side: presents results over a valid/ready handshake. Because the multiplier cannot stall, a credit counter keeps FIFO overflow impossible.

Parameters:
- N, 16, multiplicand width
- M, 16, multiplier width
- LAT, 16, multiplier latency in clock edges from operand sample to Product valid (equals M)
- DEPTH, 32, result FIFO entries; power of two, ≥1; DEPTH ≥ LAT+1 is required for sustained one-op-per-cycle throughput
- TAG_W, 4, user tag width carried alongside each operation

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operation this cycle
- in_md  in  N  multiplicand
- in_mr  in  M  multiplier
- in_tag  in  TAG_W  user tag
- mul_multiplicand  out  N  to multiplier multiplicand input
- mul_multiplier  out  M  to multiplier multiplier input
- mul_product  in  N+M  from multiplier Product output
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_product  out  N+M  result
- out_tag  out  TAG_W  tag of result

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst, and the multiplier shares the same rst.
- Issue: an operation is accepted on a clock edge where in_valid & in_ready. mul_multiplicand/mul_multiplier = in_md/in_mr when in_valid & in_ready, else 0 (combinational). Idle slots therefore carry 0×0.
- Tracking: vld_pipe[LAT] and tag_pipe[LAT] shift every cycle, unconditionally. Stage 0 loads (in_valid & in_ready, in_tag).
  - An op accepted at edge t reaches the pipe tail at edge t+LAT-1.
  - At the following edge, t+LAT, mul_product holds its product and is pushed into the FIFO with the tail tag.
- FIFO: first-word-fall-through.
  - out_valid = !empty; out_product/out_tag show the head entry.
  - Pop on out_valid & out_ready. Push and pop in the same cycle are both honoured.
  - Push into a full FIFO cannot occur by construction. The bench asserts this.
- Latency: out_valid rises LAT+1 cycles after the accept edge when the FIFO was empty. Order is strictly in-order; tags are returned unchanged.
- Credit counter cnt, width clog2(DEPTH+1):
  - cnt = ops in flight + FIFO occupancy.
  - +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
  - in_ready = (cnt < DEPTH), driven from the registered cnt with no same-cycle pop bypass. A pop at count DEPTH raises in_ready the next cycle.
- Pointers: rd/wr pointers wrap modulo DEPTH; an extra MSB distinguishes full from empty.
- Reset (including mid-operation):
  - Clears vld_pipe, tag_pipe, FIFO pointers and cnt. In-flight and buffered results are discarded.
  - Reset values: out_valid=0, out_product=0, out_tag=0 (head register cleared), in_ready=1 from the first cycle after rst deasserts, mul_* = 0 while rst=1.
- Unsigned arithmetic only. Product width N+M, no truncation.

Decomposition:
- Package mul_pkg holds N, M, LAT (derived = M), PROD_W = N+M, TAG_W, and the clog2-based CNT_W/PTR_W helpers.
- One sub-module, mul_result_fifo: parameterised by width PROD_W+TAG_W and DEPTH, FWFT, with push/pop/full/empty.
- Credit counter and tracking pipe stay in the top.

Test Plan:
- Single op: in_md=3, in_mr=5, tag=0xA with out_ready=1 -> out_valid high exactly LAT+1=17 cycles after accept, out_product=15, out_tag=0xA, one cycle only.
- Max operands back-to-back: 0xFFFF×0xFFFF, then 0xFFFF×1, then 0×0x1234 on consecutive cycles -> results 0xFFFE0001, 0x0000FFFF, 0x00000000 in order on consecutive cycles.
- Backpressure: out_ready=0 with in_valid held high -> exactly DEPTH=32 ops accepted, then in_ready=0; after the pipe drains, FIFO full with no overflow. Then out_ready=1 -> all 32 results are popped in order, and in_ready returns 1 the cycle after the first pop.
- Simultaneous pop and accept at cnt=DEPTH-1 -> cnt stays DEPTH-1 and in_ready stays 1.
- Reset mid-flight: issue 5 ops, assert rst for 1 cycle at cycle 8 -> no out_valid ever appears for those ops; in_ready=1 and cnt=0 after reset; a new op 7×9 returns 63 after LAT+1 cycles.
- Random stress: random in_valid/out_ready at 50% with a reference model -> all products and tags match and are in order, and the FIFO never pushes while full.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared widths and sizing helpers for the multiplier issue/collect wrapper.
package mul_pkg;
    localparam int N      = 16;
    localparam int M      = 16;
    localparam int LAT    = M;
    localparam int PROD_W = N + M;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 32;

    // Credit counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers carry one bit beyond the index so full and empty differ.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/mul_result_fifo.sv
// First-word-fall-through result FIFO; the head reads as zero while empty.
module mul_result_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = mul_pkg::ptr_w(DEPTH);
    localparam int IW = mul_pkg::idx_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr - rd_ptr) == PW'(DEPTH));
    assign wr_idx  = (DEPTH == 1) ? '0 : IW'(wr_ptr);
    assign rd_idx  = (DEPTH == 1) ? '0 : IW'(rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= wdata;
    end
endmodule

// File: rtl/mul_issue_collect.sv
// Issues operand pairs into a fixed-latency multiplier, tracks them with a
// valid/tag pipe and collects products into a credit-protected result FIFO.
module mul_issue_collect
    import mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_md,
    input  logic [M-1:0]      in_mr,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [N-1:0]      mul_multiplicand,
    output logic [M-1:0]      mul_multiplier,
    input  logic [PROD_W-1:0] mul_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_product,
    output logic [TAG_W-1:0]  out_tag
);
    localparam int CW = cnt_w(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and in_ready comes only from registered cnt.
    logic                    accept;
    logic                    pop;
    logic                    push;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    vld_pipe [LAT];
    logic [TAG_W-1:0]        tag_pipe [LAT];
    logic [CW-1:0]           cnt;
    logic [PROD_W+TAG_W-1:0] head;

    assign in_ready         = !rst && (cnt < CW'(DEPTH));
    assign accept           = in_valid && in_ready;
    assign mul_multiplicand = accept ? in_md : '0;
    assign mul_multiplier   = accept ? in_mr : '0;
    assign pop              = out_valid && out_ready;
    assign push             = vld_pipe[LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                vld_pipe[i] <= 1'b0;
                tag_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= accept;
            tag_pipe[0] <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // cnt covers ops in flight plus FIFO occupancy, so a push can never overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    mul_result_fifo #(
        .W     (PROD_W + TAG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({mul_product, tag_pipe[LAT-1]}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb assert (!(push && fifo_full));

    assign out_valid            = !fifo_empty;
    assign {out_product, out_tag} = head;
endmodule

// File: tb/tb_mul_issue_collect.sv
// Bench for mul_issue_collect with a behavioural multiplier and a queue model.
module tb_mul_issue_collect;
    import mul_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N-1:0]      in_md = '0;
    logic [M-1:0]      in_mr = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic [N-1:0]      mul_multiplicand;
    logic [M-1:0]      mul_multiplier;
    logic [PROD_W-1:0] mul_product;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PROD_W-1:0] out_product;
    logic [TAG_W-1:0]  out_tag;

    always #5 clk = ~clk;

    mul_issue_collect dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_md            (in_md),
        .in_mr            (in_mr),
        .in_tag           (in_tag),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .out_tag          (out_tag)
    );

    // Behavioural multiplier: LAT-deep product pipe, no stall.
    logic [PROD_W-1:0] mpipe [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
        end else begin
            mpipe[0] <= PROD_W'(mul_multiplicand) * PROD_W'(mul_multiplier);
            for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_product = mpipe[LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: every accepted op is owed back in order, visible LAT
    // edges after its accept edge; outstanding ops never exceed DEPTH.
    logic [PROD_W+TAG_W-1:0] exp_q[$];
    int                      due_q[$];
    logic [PROD_W+TAG_W-1:0] got_q[$];
    int                      edge_n = 0;

    function automatic logic m_ready();
        return exp_q.size() < DEPTH;
    endfunction

    function automatic logic m_out_valid();
        return (exp_q.size() > 0) && (due_q[0] + LAT <= edge_n);
    endfunction

    task automatic check_outputs();
        check_eq("in_ready", in_ready, m_ready());
        check_eq("out_valid", out_valid, m_out_valid());
        if (m_out_valid()) begin
            check_eq("out_product", out_product, exp_q[0][PROD_W+TAG_W-1:TAG_W]);
            check_eq("out_tag", out_tag, exp_q[0][TAG_W-1:0]);
        end
    endtask

    // Called at the falling edge: drive, check issue outputs, advance one edge.
    task automatic tick(input logic iv, input logic [N-1:0] md, input logic [M-1:0] mr,
                        input logic [TAG_W-1:0] tg, input logic ordy);
        logic acc;
        logic pp;
        in_valid = iv; in_md = md; in_mr = mr; in_tag = tg; out_ready = ordy;
        #1;
        acc = iv && m_ready();
        pp  = ordy && m_out_valid();
        check_eq("mul_multiplicand", mul_multiplicand, acc ? md : '0);
        check_eq("mul_multiplier", mul_multiplier, acc ? mr : '0);
        check_eq("no_push_when_full", dut.u_fifo.push && dut.u_fifo.full, 1'b0);
        if (pp) got_q.push_back({out_product, out_tag});
        @(posedge clk);
        edge_n++;
        if (pp) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
        if (acc) begin
            exp_q.push_back({PROD_W'(md) * PROD_W'(mr), tg});
            due_q.push_back(edge_n);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, '0, ordy);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; in_valid = 1'b1; in_md = 16'hBEEF; in_mr = 16'h1234; in_tag = 4'h5; out_ready = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            check_eq("rst_mul_multiplicand", mul_multiplicand, '0);
            check_eq("rst_mul_multiplier", mul_multiplier, '0);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete(); due_q.delete();
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_product", out_product, '0);
        check_eq("rst_out_tag", out_tag, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick(1'b0, '0, '0, '0, 1'b1);
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick(1'b0, '0, '0, '0, 1'b1);
            lat++;
        end
        check_eq(tag, lat, exp_lat);
    endtask

    initial begin
        int n_acc;
        logic [N-1:0] md;
        logic [M-1:0] mr;

        @(negedge clk);
        do_reset(2);

        // Single op latency and one-cycle result.
        tick(1'b1, 16'd3, 16'd5, 4'hA, 1'b1);
        wait_result("single_latency", LAT + 1);
        check_eq("single_product", out_product, 32'd15);
        check_eq("single_tag", out_tag, 4'hA);
        tick(1'b0, '0, '0, '0, 1'b1);
        check_eq("single_one_cycle", out_valid, 1'b0);

        // Extreme operands back to back.
        got_q.delete();
        tick(1'b1, 16'hFFFF, 16'hFFFF, 4'h1, 1'b1);
        tick(1'b1, 16'hFFFF, 16'h0001, 4'h2, 1'b1);
        tick(1'b1, 16'h0000, 16'h1234, 4'h3, 1'b1);
        idle(LAT + 4, 1'b1);
        check_eq("b2b_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check_eq("b2b_r0", got_q[0], {32'hFFFE0001, 4'h1});
            check_eq("b2b_r1", got_q[1], {32'h0000FFFF, 4'h2});
            check_eq("b2b_r2", got_q[2], {32'h00000000, 4'h3});
        end

        // Backpressure: credits stop acceptance at DEPTH.
        n_acc = 0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            n_acc += int'(in_ready);
            tick(1'b1, 16'($urandom), 16'($urandom), 4'($urandom), 1'b0);
        end
        check_eq("bp_accepted", n_acc, DEPTH);
        check_eq("bp_in_ready_low", in_ready, 1'b0);
        for (int i = 0; i < LAT + 2; i++) tick(1'b1, 16'h1111, 16'h2222, 4'h7, 1'b0);
        check_eq("bp_fifo_full", dut.u_fifo.full, 1'b1);
        check_eq("bp_out_valid", out_valid, 1'b1);
        got_q.delete();
        tick(1'b1, 16'h1111, 16'h2222, 4'h7, 1'b1);
        check_eq("bp_ready_after_pop", in_ready, 1'b1);
        idle(DEPTH + 4, 1'b1);
        check_eq("bp_popped", got_q.size(), DEPTH);

        // Simultaneous pop and accept at DEPTH-1 outstanding.
        for (int i = 0; i < DEPTH - 1; i++) tick(1'b1, 16'(i), 16'(i + 3), 4'(i), 1'b0);
        idle(LAT + 2, 1'b0);
        tick(1'b1, 16'h00AA, 16'h0055, 4'hC, 1'b1);
        check_eq("pa_outstanding", exp_q.size(), DEPTH - 1);
        check_eq("pa_in_ready", in_ready, 1'b1);
        tick(1'b0, '0, '0, '0, 1'b0);
        check_eq("pa_in_ready_hold", in_ready, 1'b1);
        drain();

        // Reset with operations in flight.
        for (int i = 0; i < 5; i++) tick(1'b1, 16'(i + 1), 16'(i + 10), 4'(i), 1'b1);
        idle(2, 1'b1);
        do_reset(1);
        idle(LAT + 6, 1'b1);
        check_eq("mr_no_stale", out_valid, 1'b0);
        tick(1'b1, 16'd7, 16'd9, 4'h6, 1'b1);
        wait_result("mr_latency", LAT + 1);
        check_eq("mr_product", out_product, 32'd63);
        check_eq("mr_tag", out_tag, 4'h6);
        drain();

        // Random stress.
        for (int i = 0; i < 2000; i++) begin
            md = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            mr = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            tick(1'($urandom_range(0, 1)), md, mr, 4'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
